// File: rtl/r2b_converter_if.sv
// Stream bundle for the row-to-block converter: tile input, super-block output, enable.
// Latency: none (wires only).
// Backpressure: valid/ready on both sides; en_r2b gates both sides.
//
// master: drives en_r2b, in_valid, in_data, out_ready (upstream + downstream agent)
// slave : drives in_ready, out_valid, out_data, frame_done (the converter)
interface r2b_converter_if #(
    parameter int WIDTH     = 16,
    parameter int TILE_SIZE = 4,
    parameter int OUT_ELEM  = 24
);
    logic                          en_r2b;
    logic                          in_valid;
    logic                          in_ready;
    logic [WIDTH*TILE_SIZE-1:0]    in_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [WIDTH*OUT_ELEM-1:0]     out_data;
    logic                          frame_done;

    modport master (
        output en_r2b, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, frame_done
    );

    modport slave (
        input  en_r2b, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, frame_done
    );
endinterface

// File: rtl/r2b_converter.sv
// Row-major tile stream to block-format super-block words, ping-pong strip buffers.
// Latency: first word of a strip is valid 1 cycle after the strip-completing tile.
// Backpressure: in_ready drops only when the write bank is still full; output held while !out_ready.
//
// Ports: clk, rst_n (async active-low), bus (slave modport of r2b_converter_if):
//   en_r2b freezes all state when low; in_valid/in_ready/in_data tile input (element 0 in MSBs);
//   out_valid/out_ready/out_data super-block output (element k at [(k+1)*WIDTH-1 -: WIDTH]);
//   frame_done pulses on the handshake of the final word of the matrix.
module r2b_converter #(
    parameter int WIDTH       = 16,
    parameter int FRAC_WIDTH  = 8,
    parameter int ROW         = 12,
    parameter int COL         = 12,
    parameter int BLOCK_SIZE  = 2,
    parameter int CHUNK_SIZE  = 4,
    parameter int NUM_CORES_H = 3,
    parameter int NUM_CORES_V = 2,
    parameter int TILE_SIZE   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    r2b_converter_if.slave    bus
);
    localparam int SB_ROWS  = NUM_CORES_V * BLOCK_SIZE;
    localparam int SB_COLS  = NUM_CORES_H * BLOCK_SIZE;
    localparam int OUT_ELEM = CHUNK_SIZE * NUM_CORES_H * NUM_CORES_V;
    localparam int STRIP    = SB_ROWS * COL;
    localparam int TPR      = COL / TILE_SIZE;   // tiles per matrix row
    localparam int WPS      = COL / SB_COLS;     // output words per strip
    localparam int NSTRIPS  = ROW / SB_ROWS;     // strips per frame
    localparam int TW       = (TPR > 1)     ? $clog2(TPR)     : 1;
    localparam int RW       = (SB_ROWS > 1) ? $clog2(SB_ROWS) : 1;
    localparam int JW       = (WPS > 1)     ? $clog2(WPS)     : 1;
    localparam int SW       = (NSTRIPS > 1) ? $clog2(NSTRIPS) : 1;
    localparam int AW       = (STRIP > 1)   ? $clog2(STRIP)   : 1;

    if ((COL % TILE_SIZE != 0) || (COL % SB_COLS != 0) || (ROW % SB_ROWS != 0)) begin : g_chk_geom
        $fatal(1, "r2b_converter: COL/ROW must tile evenly into TILE_SIZE and super-blocks");
    end
    if ((CHUNK_SIZE != BLOCK_SIZE * BLOCK_SIZE) || (FRAC_WIDTH > WIDTH)) begin : g_chk_block
        $fatal(1, "r2b_converter: CHUNK_SIZE must be BLOCK_SIZE^2 and FRAC_WIDTH <= WIDTH");
    end

    logic [WIDTH-1:0]          mem_q [2][STRIP];
    logic [WIDTH-1:0]          mem_d [2][STRIP];
    // run_q keeps in_ready low while reset is held and for the first edge after it.
    logic                      run_q, run_d;
    logic                      wr_bank_q, wr_bank_d;
    logic                      rd_bank_q, rd_bank_d;
    logic [1:0]                full_q, full_d;
    logic [TW-1:0]             wr_tile_q, wr_tile_d;
    logic [RW-1:0]             wr_row_q, wr_row_d;
    logic [JW-1:0]             rd_word_q, rd_word_d;
    logic [SW-1:0]             strip_q, strip_d;
    logic                      out_valid_q, out_valid_d;
    logic [WIDTH*OUT_ELEM-1:0] out_data_q, out_data_d;
    // Set when the word now in the output register is the last word of the frame.
    logic                      last_q, last_d;

    logic                      in_ready_c, accept, hs, load, rd_last_word;
    logic [WIDTH*OUT_ELEM-1:0] word_c;

    // Write side
    always_comb begin
        run_d      = 1'b1;
        in_ready_c = run_q && bus.en_r2b && !full_q[wr_bank_q];
        accept     = bus.in_valid && in_ready_c;
        mem_d      = mem_q;
        wr_tile_d  = wr_tile_q;
        wr_row_d   = wr_row_q;
        wr_bank_d  = wr_bank_q;
        if (accept) begin
            for (int i = 0; i < TILE_SIZE; i++) begin
                mem_d[wr_bank_q][AW'(int'(wr_row_q) * COL + int'(wr_tile_q) * TILE_SIZE + i)] =
                    bus.in_data[(TILE_SIZE - i) * WIDTH - 1 -: WIDTH];
            end
            if (wr_tile_q == TW'(TPR - 1)) begin
                wr_tile_d = '0;
                wr_row_d  = (wr_row_q == RW'(SB_ROWS - 1)) ? '0 : wr_row_q + 1'b1;
                if (wr_row_q == RW'(SB_ROWS - 1)) begin
                    wr_bank_d = ~wr_bank_q;
                end
            end else begin
                wr_tile_d = wr_tile_q + 1'b1;
            end
        end
    end

    // Gather word rd_word_q of the read bank: element k comes from core k/CHUNK_SIZE,
    // cores laid out row-major over the NUM_CORES_V x NUM_CORES_H grid, each chunk row-major.
    always_comb begin
        word_c = '0;
        for (int k = 0; k < OUT_ELEM; k++) begin
            word_c[k * WIDTH +: WIDTH] = mem_q[rd_bank_q][AW'(
                (((k / CHUNK_SIZE) / NUM_CORES_H) * BLOCK_SIZE + (k % CHUNK_SIZE) / BLOCK_SIZE) * COL
                + int'(rd_word_q) * SB_COLS
                + ((k / CHUNK_SIZE) % NUM_CORES_H) * BLOCK_SIZE
                + (k % CHUNK_SIZE) % BLOCK_SIZE)];
        end
    end

    // Read side and bank occupancy
    always_comb begin
        hs           = bus.en_r2b && out_valid_q && bus.out_ready;
        load         = bus.en_r2b && full_q[rd_bank_q] && (!out_valid_q || bus.out_ready);
        rd_last_word = (rd_word_q == JW'(WPS - 1));
        full_d       = full_q;
        rd_bank_d    = rd_bank_q;
        rd_word_d    = rd_word_q;
        strip_d      = strip_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        last_d       = last_q;
        // Write and read banks always differ here: writing needs !full, reading needs full.
        if (accept && (wr_tile_q == TW'(TPR - 1)) && (wr_row_q == RW'(SB_ROWS - 1))) begin
            full_d[wr_bank_q] = 1'b1;
        end
        if (load) begin
            out_data_d  = word_c;
            out_valid_d = 1'b1;
            last_d      = rd_last_word && (strip_q == SW'(NSTRIPS - 1));
            if (rd_last_word) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
                rd_word_d         = '0;
                strip_d           = (strip_q == SW'(NSTRIPS - 1)) ? '0 : strip_q + 1'b1;
            end else begin
                rd_word_d = rd_word_q + 1'b1;
            end
        end else if (hs) begin
            out_valid_d = 1'b0;
            last_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q       <= 1'b0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_q      <= '0;
            wr_tile_q   <= '0;
            wr_row_q    <= '0;
            rd_word_q   <= '0;
            strip_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            last_q      <= 1'b0;
        end else begin
            run_q       <= run_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            full_q      <= full_d;
            wr_tile_q   <= wr_tile_d;
            wr_row_q    <= wr_row_d;
            rd_word_q   <= rd_word_d;
            strip_q     <= strip_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            last_q      <= last_d;
        end
    end

    // Strip storage carries no reset; occupancy flags alone decide what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.frame_done = hs && last_q;
endmodule

// File: tb/tb_r2b_converter.sv
module tb_r2b_converter;
    localparam int WIDTH = 16, ROW = 12, COL = 12, BS = 2, CS = 4, NH = 3, NV = 2, TS = 4;
    localparam int SBR = NV * BS, SBC = NH * BS, OE = CS * NH * NV;
    localparam int TPR = COL / TS, WPS = COL / SBC, NSTR = ROW / SBR;
    typedef logic [WIDTH*OE-1:0] word_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    r2b_converter_if #(.WIDTH(WIDTH), .TILE_SIZE(TS), .OUT_ELEM(OE)) bus ();

    r2b_converter #(
        .WIDTH(WIDTH), .FRAC_WIDTH(8), .ROW(ROW), .COL(COL), .BLOCK_SIZE(BS),
        .CHUNK_SIZE(CS), .NUM_CORES_H(NH), .NUM_CORES_V(NV), .TILE_SIZE(TS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int        tests = 0, fails = 0;
    longint    cyc = 0;
    logic [WIDTH-1:0] mat [ROW][COL];
    word_t     exp_q[$];
    bit        exp_fd[$];
    word_t     got[$];
    int        fd_words[$];
    int        w_cnt = 0;
    int        rdy_mode = 0;
    int        gap_pct = 0;
    int        tiles_acc = 0;
    longint    tile12_cyc = 0, first_vld_cyc = 0;
    bit        first_seen = 0;
    bit        send_done = 0;
    bit        hold_pend = 0;
    word_t     hold_dat;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_w(string nm, word_t act, word_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_i(string nm, longint act, longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic bail(string nm);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting on DUT", nm);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    // Reference: every word of the frame from the matrix, core grid row-major, each 2x2 chunk row-major.
    task automatic push_words();
        word_t w;
        for (int s = 0; s < NSTR; s++) begin
            for (int j = 0; j < WPS; j++) begin
                w = '0;
                for (int v = 0; v < NV; v++)
                    for (int h = 0; h < NH; h++)
                        for (int br = 0; br < BS; br++)
                            for (int bc = 0; bc < BS; bc++)
                                w[((v * NH + h) * CS + br * BS + bc) * WIDTH +: WIDTH] =
                                    mat[s * SBR + v * BS + br][j * SBC + h * BS + bc];
                exp_q.push_back(w);
                exp_fd.push_back((s == NSTR - 1) && (j == WPS - 1));
            end
        end
    endtask

    // Sends one frame. abort_at>0 stops after that many tiles; pause_at>0 drops en_r2b for 5 cycles after it.
    task automatic send_frame(bit pat, int abort_at, int pause_at);
        logic [WIDTH*TS-1:0] d;
        int n = 0;
        int budget;
        bit acc;
        word_t snap;
        logic snap_v;
        for (int r = 0; r < ROW; r++)
            for (int c = 0; c < COL; c++)
                mat[r][c] = pat ? WIDTH'((r * COL + c) << 8) : WIDTH'($urandom);
        push_words();
        for (int r = 0; r < ROW; r++) begin
            for (int t = 0; t < TPR; t++) begin
                for (int i = 0; i < TS; i++) d[(TS - i) * WIDTH - 1 -: WIDTH] = mat[r][t * TS + i];
                while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                    bus.in_valid = 1'b0;
                    @(posedge clk); #1;
                end
                bus.in_valid = 1'b1;
                bus.in_data  = d;
                acc = 0;
                budget = 0;
                while (!acc) begin
                    @(negedge clk);
                    acc = bus.in_ready;
                    @(posedge clk); #1;
                    budget++;
                    if (budget > 3000) bail("tile_accept");
                end
                n++;
                tiles_acc++;
                if (tiles_acc == 12) tile12_cyc = cyc;
                if (n == pause_at) begin
                    bus.in_valid = 1'b0;
                    bus.en_r2b   = 1'b0;
                    snap   = bus.out_data;
                    snap_v = bus.out_valid;
                    for (int p = 0; p < 5; p++) begin
                        @(negedge clk);
                        chk_i("en_off_in_ready", bus.in_ready, 0);
                        chk_i("en_off_valid", bus.out_valid, snap_v);
                        chk_w("en_off_data", bus.out_data, snap);
                        @(posedge clk); #1;
                    end
                    bus.en_r2b = 1'b1;
                end
                if (n == abort_at) begin
                    bus.in_valid = 1'b0;
                    return;
                end
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int budget = 0;
        while (exp_q.size() != 0) begin
            @(posedge clk); #1;
            budget++;
            if (budget > 3000) bail("drain");
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Downstream ready agent.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(1));
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Per-cycle compare against the reference queue, plus output stability under stall.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend = 0;
        end else begin
            if (hold_pend) begin
                chk_i("hold_valid", bus.out_valid, 1);
                chk_w("hold_data", bus.out_data, hold_dat);
            end
            hold_pend = 0;
            if (bus.out_valid && !(bus.en_r2b && bus.out_ready)) begin
                hold_pend = 1;
                hold_dat  = bus.out_data;
            end
            if (bus.out_valid && !first_seen) begin
                first_seen    = 1;
                first_vld_cyc = cyc;
            end
            if (bus.out_valid && bus.en_r2b && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk_i("unexpected_word", 1, 0);
                end else begin
                    chk_w($sformatf("word%0d", w_cnt), bus.out_data, exp_q.pop_front());
                    chk_i($sformatf("frame_done_w%0d", w_cnt), bus.frame_done, exp_fd.pop_front());
                end
                got.push_back(bus.out_data);
                w_cnt++;
                if (bus.frame_done) fd_words.push_back(w_cnt);
            end else begin
                chk_i("frame_done_idle", bus.frame_done, 0);
            end
        end
    end

    initial begin
        int base, wb, fb;
        word_t w;
        bus.en_r2b   = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_i("rst_out_valid", bus.out_valid, 0);
        chk_w("rst_out_data", bus.out_data, '0);
        chk_i("rst_frame_done", bus.frame_done, 0);
        chk_i("rst_in_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 1: pattern frame, full throughput
        tiles_acc = 0; first_seen = 0;
        base = got.size(); wb = w_cnt; fb = fd_words.size();
        send_frame(1, -1, -1);
        wait_drain();
        chk_i("latency_after_tile12", first_vld_cyc - tile12_cyc, 1);
        chk_i("t1_words", w_cnt - wb, 6);
        if (got.size() >= base + 6) begin
            w = got[base];
            chk_i("w0_e0", w[0*WIDTH +: WIDTH], 16'h0000);
            chk_i("w0_e1", w[1*WIDTH +: WIDTH], 16'h0100);
            chk_i("w0_e2", w[2*WIDTH +: WIDTH], 16'h0C00);
            chk_i("w0_e3", w[3*WIDTH +: WIDTH], 16'h0D00);
            chk_i("w0_e12", w[12*WIDTH +: WIDTH], 16'h1800);
            w = got[base + 1];
            chk_i("w1_e0", w[0*WIDTH +: WIDTH], 16'h0600);
            w = got[base + 5];
            chk_i("w5_e23", w[23*WIDTH +: WIDTH], 16'h8F00);
        end
        chk_i("t1_fd_count", fd_words.size() - fb, 1);
        if (fd_words.size() > fb) chk_i("t1_fd_on_word6", fd_words[fb] - wb, 6);

        // 2: output held off while the input keeps feeding
        rdy_mode = 2; tiles_acc = 0; send_done = 0; wb = w_cnt;
        fork
            begin
                send_frame(1, -1, -1);
                send_done = 1;
            end
        join_none
        repeat (60) @(posedge clk);
        @(negedge clk);
        chk_i("bp_tiles_taken", tiles_acc, 24);
        chk_i("bp_in_ready", bus.in_ready, 0);
        chk_i("bp_out_valid", bus.out_valid, 1);
        if (exp_q.size() > 0) chk_w("bp_word0", bus.out_data, exp_q[0]);
        rdy_mode = 0;
        for (int b = 0; b < 3000 && !send_done; b++) @(posedge clk);
        if (!send_done) bail("bp_send");
        #1;
        wait_drain();
        chk_i("bp_words", w_cnt - wb, 6);

        // 3: random data, random input gaps, random ready
        rdy_mode = 1; gap_pct = 30; wb = w_cnt;
        send_frame(0, -1, -1);
        send_frame(0, -1, -1);
        wait_drain();
        chk_i("rand_words", w_cnt - wb, 12);
        rdy_mode = 0; gap_pct = 0;

        // 4: enable dropped mid-strip
        wb = w_cnt;
        send_frame(1, -1, 7);
        wait_drain();
        chk_i("en_words", w_cnt - wb, 6);

        // 5: reset mid-frame with a word held in the output register
        rdy_mode = 2;
        send_frame(1, 18, -1);
        repeat (2) @(posedge clk);
        #1;
        chk_i("pre_rst_valid", bus.out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk_i("midrst_out_valid", bus.out_valid, 0);
        chk_w("midrst_out_data", bus.out_data, '0);
        chk_i("midrst_in_ready", bus.in_ready, 0);
        chk_i("midrst_frame_done", bus.frame_done, 0);
        exp_q.delete();
        exp_fd.delete();
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        wb = w_cnt; fb = fd_words.size();
        send_frame(0, -1, -1);
        wait_drain();
        chk_i("post_rst_words", w_cnt - wb, 6);
        chk_i("post_rst_fd_count", fd_words.size() - fb, 1);

        // 6: two frames back to back
        wb = w_cnt; fb = fd_words.size();
        send_frame(0, -1, -1);
        send_frame(0, -1, -1);
        wait_drain();
        chk_i("two_frames_words", w_cnt - wb, 12);
        chk_i("two_frames_fd_count", fd_words.size() - fb, 2);
        if (fd_words.size() >= fb + 2) begin
            chk_i("fd_first_on_word6", fd_words[fb] - wb, 6);
            chk_i("fd_second_on_word12", fd_words[fb + 1] - wb, 12);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
